// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the unified memory initiator
package mem_pkg;
   localparam int WORD_W        = 32;
   localparam int DEFAULT_DEPTH = 200;
   localparam int CNT_W         = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      RESP
   } state_t;
endpackage

// File: rtl/mem_wait_cnt.sv
// rtl/mem_wait_cnt.sv - loadable down-counter that spaces acceptance from the memory access
module mem_wait_cnt
   import mem_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             dec,
   output logic [CNT_W-1:0] value,
   output logic             zero
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (dec && (value != '0)) begin
         value <= value - CNT_W'(1);
      end
   end

   assign zero = (value == '0);

endmodule

// File: rtl/mem_master.sv
// rtl/mem_master.sv - request/response initiator for the single-port unified memory
// Optional misaligned-address error enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_master
   import mem_pkg::*;
#(
   parameter int DEPTH       = DEFAULT_DEPTH,
   parameter int WAIT_CYCLES = 0,
   parameter int AW          = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [AW-1:0]     req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_a,
   output logic [WORD_W-1:0] mem_wd,
   input  logic [WORD_W-1:0] mem_rd
);

   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   state_t            state;
   logic              we_q;
   logic              err_q;
   logic [WORD_W-1:0] req_idx;
   logic              req_err;
   logic              cnt_load;
   logic              cnt_zero;
   logic [CNT_W-1:0]  cnt_value;

   assign req_idx = WORD_W'(req_addr >> 2);

`ifdef MEM_MISALIGN_CHECK_EN
   assign req_err = (req_idx >= WORD_W'(DEPTH)) || (req_addr[1:0] != 2'b00);
`else
   assign req_err = (req_idx >= WORD_W'(DEPTH));
`endif

   assign cnt_load = (state == IDLE) && req_valid;

   mem_wait_cnt u_wait_cnt (
      .clk        (clk),
      .reset      (reset),
      .load       (cnt_load),
      .load_value (WAIT_LOAD),
      .dec        (state == WAIT),
      .value      (cnt_value),
      .zero       (cnt_zero)
   );

   // Decoded from state so that an asynchronous reset kills a write pulse at once.
   assign req_ready = (state == IDLE) && !reset;
   assign mem_we    = (state == ACCESS) && we_q && !err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         mem_a      <= '0;
         mem_wd     <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q   <= req_we;
                  err_q  <= req_err;
                  mem_a  <= req_idx;
                  mem_wd <= req_wdata;
                  state  <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
               end
            end
            WAIT: begin
               if (cnt_zero) state <= ACCESS;
            end
            ACCESS: begin
               resp_rdata <= (!we_q && !err_q) ? mem_rd : '0;
               resp_err   <= err_q;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - scoreboard bench driving zero-wait and three-wait instances in lockstep
module tb_mem_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we, resp_ready;
   logic [31:0] req_addr, req_wdata;

   logic        req_ready0, resp_valid0, resp_err0, mem_we0;
   logic [31:0] resp_rdata0, mem_a0, mem_wd0, mem_rd0;
   logic        req_ready3, resp_valid3, resp_err3, mem_we3;
   logic [31:0] resp_rdata3, mem_a3, mem_wd3, mem_rd3;

   logic [31:0] mem0  [0:255];
   logic [31:0] mem3  [0:255];
   logic [31:0] model [0:255];

   logic [32:0] q0[$];
   logic [32:0] q3[$];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_master #(.WAIT_CYCLES(0)) u0 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready0),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_rdata(resp_rdata0),
      .resp_err(resp_err0), .mem_we(mem_we0), .mem_a(mem_a0), .mem_wd(mem_wd0),
      .mem_rd(mem_rd0)
   );

   mem_master #(.WAIT_CYCLES(3)) u3 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready3),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid3), .resp_ready(resp_ready), .resp_rdata(resp_rdata3),
      .resp_err(resp_err3), .mem_we(mem_we3), .mem_a(mem_a3), .mem_wd(mem_wd3),
      .mem_rd(mem_rd3)
   );

   assign mem_rd0 = (mem_a0 < 32'd256) ? mem0[mem_a0[7:0]] : 32'hBAD0BAD0;
   assign mem_rd3 = (mem_a3 < 32'd256) ? mem3[mem_a3[7:0]] : 32'hBAD0BAD0;

   always @(posedge clk) begin
      if (mem_we0 && mem_a0 < 32'd256) mem0[mem_a0[7:0]] <= mem_wd0;
      if (mem_we3 && mem_a3 < 32'd256) mem3[mem_a3[7:0]] <= mem_wd3;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input bit which, input logic err, input logic [31:0] rdata);
      logic [32:0] e;
      if (which ? (q3.size() == 0) : (q0.size() == 0)) begin
         chk({tag, "/queue_empty"}, 32'd1, 32'd0);
      end else begin
         e = which ? q3.pop_front() : q0.pop_front();
         chk({tag, "/rdata"}, rdata, e[31:0]);
         chk({tag, "/err"}, 32'(err), 32'(e[32]));
      end
   endtask

   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input bit bp, input string tag);
      logic [31:0] idx;
      logic        err;
      logic [31:0] hold0, hold3, acc_a0, acc_a3, wa0, wa3;
      int          lat0, lat3, vcnt0, vcnt3, wcnt0, wcnt3, ncyc, exp_w;
      bit          rdy3_ok, stab_ok;
      idx = addr >> 2;
      err = (idx >= 32'd200);
`ifdef MEM_MISALIGN_CHECK_EN
      if (addr[1:0] != 2'b00) err = 1'b1;
`endif
      q0.push_back({err, (!we && !err) ? model[idx[7:0]] : 32'h0});
      q3.push_back({err, (!we && !err) ? model[idx[7:0]] : 32'h0});
      if (we && !err) model[idx[7:0]] = wd;
      exp_w = (we && !err) ? 1 : 0;

      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; resp_ready = !bp;
      chk({tag, "/req_ready"}, 32'(req_ready0 & req_ready3), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;

      lat0 = 0; lat3 = 0; vcnt0 = 0; vcnt3 = 0; wcnt0 = 0; wcnt3 = 0;
      hold0 = '0; hold3 = '0; acc_a0 = '0; acc_a3 = '0; wa0 = '0; wa3 = '0;
      rdy3_ok = 1'b1; stab_ok = 1'b1;
      ncyc = bp ? 9 : 7;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (k == 1) acc_a0 = mem_a0;
         if (k == 4) acc_a3 = mem_a3;
         if (mem_we0) begin wcnt0++; wa0 = mem_a0; end
         if (mem_we3) begin wcnt3++; wa3 = mem_a3; end
         if (lat3 == 0 && req_ready3) rdy3_ok = 1'b0;
         if (resp_valid0) begin
            vcnt0++;
            if (lat0 == 0) begin
               lat0 = k; hold0 = resp_rdata0;
               pop_chk({tag, "/u0"}, 1'b0, resp_err0, resp_rdata0);
            end else if (resp_rdata0 !== hold0) stab_ok = 1'b0;
         end
         if (resp_valid3) begin
            vcnt3++;
            if (lat3 == 0) begin
               lat3 = k; hold3 = resp_rdata3;
               pop_chk({tag, "/u3"}, 1'b1, resp_err3, resp_rdata3);
            end else if (resp_rdata3 !== hold3) stab_ok = 1'b0;
         end
         if (bp && k == 8) resp_ready = 1'b1;
      end

      chk({tag, "/lat_u0"}, 32'(lat0), 32'd2);
      chk({tag, "/lat_u3"}, 32'(lat3), 32'd5);
      chk({tag, "/mem_a_u0"}, acc_a0, idx);
      chk({tag, "/mem_a_u3"}, acc_a3, idx);
      chk({tag, "/we_pulses_u0"}, 32'(wcnt0), 32'(exp_w));
      chk({tag, "/we_pulses_u3"}, 32'(wcnt3), 32'(exp_w));
      if (exp_w == 1) begin
         chk({tag, "/we_addr_u0"}, wa0, idx);
         chk({tag, "/we_addr_u3"}, wa3, idx);
      end
      chk({tag, "/ready_low_u3"}, 32'(rdy3_ok), 32'd1);
      chk({tag, "/valid_cycles_u0"}, 32'(vcnt0), bp ? 32'd7 : 32'd1);
      chk({tag, "/valid_cycles_u3"}, 32'(vcnt3), bp ? 32'd4 : 32'd1);
      if (bp) chk({tag, "/stable"}, 32'(stab_ok), 32'd1);
      resp_ready = 1'b1;
   endtask

   initial begin
      int diff0, diff3;
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      resp_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         mem0[i]  = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
         mem3[i]  = mem0[i];
         model[i] = mem0[i];
      end
      mem0[5] = 32'h8C020005; mem3[5] = 32'h8C020005; model[5] = 32'h8C020005;

      @(negedge clk);
      @(negedge clk);
      chk("rst/req_ready", 32'(req_ready0 | req_ready3), 32'd0);
      chk("rst/resp_valid", 32'(resp_valid0 | resp_valid3), 32'd0);
      chk("rst/mem_we", 32'(mem_we0 | mem_we3), 32'd0);
      chk("rst/mem_a", mem_a0 | mem_a3, 32'd0);
      chk("rst/mem_wd", mem_wd0 | mem_wd3, 32'd0);
      chk("rst/resp_rdata", resp_rdata0 | resp_rdata3, 32'd0);
      chk("rst/resp_err", 32'(resp_err0 | resp_err3), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst/ready_after", 32'(req_ready0 & req_ready3), 32'd1);

      txn(1'b0, 32'h14,  32'h0,        1'b0, "rd5");
      txn(1'b1, 32'h50,  32'hDEADBEEF, 1'b0, "wr20");
      txn(1'b0, 32'h50,  32'h0,        1'b0, "rd20");
      txn(1'b1, 32'h320, 32'hCAFEF00D, 1'b0, "oor_wr");
      chk("oor_wr/word200", mem0[200], model[200]);
      txn(1'b0, 32'h320, 32'h0,        1'b0, "oor_rd");
      txn(1'b0, 32'h50,  32'h0,        1'b1, "bp_rd");
      txn(1'b0, 32'h15,  32'h0,        1'b0, "mis_rd");

      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("rst_acc/we_before", 32'(mem_we0), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_acc/we_after", 32'(mem_we0), 32'd0);
      chk("rst_acc/req_ready", 32'(req_ready0), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_acc/ready_after", 32'(req_ready0 & req_ready3), 32'd1);
      chk("rst_acc/resp_valid", 32'(resp_valid0 | resp_valid3), 32'd0);
      chk("rst_acc/word16_u0", mem0[16], model[16]);
      chk("rst_acc/word16_u3", mem3[16], model[16]);

      txn(1'b0, 32'h40, 32'h0, 1'b0, "rd16");

      diff0 = 0; diff3 = 0;
      for (int i = 0; i < 256; i++) begin
         if (mem0[i] !== model[i]) diff0++;
         if (mem3[i] !== model[i]) diff3++;
      end
      chk("final/mem_u0_diffs", 32'(diff0), 32'd0);
      chk("final/mem_u3_diffs", 32'(diff3), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
